// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the PSRV32 five-stage pipeline. It sits between
// execute and writeback. It performs RV32I loads and stores against a data
// memory that answers a request with a single acknowledge after a variable
// number of cycles. Load data is aligned and sign- or zero-extended. The
// stage holds the pipeline with a stall while an access is outstanding.
// Everything the writeback stage needs is registered in the MEM/WB register.
//
// Ports
//   clk_i, reset_i          clock (rising edge), asynchronous active-low reset
//   valid_i                 EX/MEM slot holds a live instruction
//   alu_result_i            effective address, or pass-through ALU result
//   store_data_i            rs2 value for stores
//   funct3_i                access size / signedness
//   mem_read_i/mem_write_i  load / store (never both)
//   mem_to_reg_i, reg_write_i, rd_i, pcsrc_i, offset_i   pass-through fields
//   stall_o                 upstream must hold its inputs while high
//   dmem_req_o/we_o/addr_o/wdata_o/wstrb_o   data-memory request
//   dmem_rdata_i, dmem_ack_i                 data-memory response
//   valid_o ... fault_o     MEM/WB pipeline register
// ---------------------------------------------------------------------------
module mem_access_stage (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        valid_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] store_data_i,
   input  logic [2:0]  funct3_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [1:0]  mem_to_reg_i,
   input  logic        reg_write_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] pcsrc_i,
   input  logic [31:0] offset_i,
   output logic        stall_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_wstrb_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_ack_i,
   output logic        valid_o,
   output logic [31:0] data_read_o,
   output logic [31:0] alu_result_o,
   output logic [31:0] pcsrc_o,
   output logic [31:0] offset_o,
   output logic [1:0]  mem_to_reg_o,
   output logic        reg_write_o,
   output logic [4:0]  rd_o,
   output logic        fault_o
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t state;

   // Fields captured when a memory access is launched. The retirement in
   // WAIT uses these copies, so the result never depends on what upstream
   // drives during the ack cycle.
   logic [2:0]  lat_funct3;
   logic [1:0]  lat_offset;
   logic        lat_is_store;
   logic [31:0] lat_alu_result;
   logic [31:0] lat_pcsrc;
   logic [31:0] lat_offset_field;
   logic [1:0]  lat_mem_to_reg;
   logic        lat_reg_write;
   logic [4:0]  lat_rd;

   logic        is_mem;
   logic        bad_funct3;
   logic        misaligned;
   logic        access_fault;
   logic [1:0]  byte_off;
   logic [3:0]  store_strb;
   logic [31:0] store_wdata;

   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_ext;
   logic [31:0] retire_data;

   // Stall tracks the state directly. It stays high through the ack cycle,
   // so the next instruction is taken on the first IDLE edge.
   assign stall_o = (state == WAIT);

   // Decode the incoming instruction. The access size comes from funct3[1:0].
   // The encodings 011, 110 and 111 do not name a legal RV32I access.
   always_comb begin
      is_mem       = mem_read_i | mem_write_i;
      byte_off     = alu_result_i[1:0];
      bad_funct3   = (funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                     (funct3_i == 3'b111);
      misaligned   = ((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00));
      access_fault = is_mem & (bad_funct3 | misaligned);
   end

   // Store lane encoding. Data is replicated across all lanes, so memory
   // can take the selected lane without shifting. Loads drive no strobes.
   always_comb begin
      store_strb  = 4'b0000;
      store_wdata = store_data_i;
      case (funct3_i[1:0])
         2'b00: begin
            store_strb  = 4'b0001 << byte_off;
            store_wdata = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            store_strb  = 4'b0011 << byte_off;
            store_wdata = {2{store_data_i[15:0]}};
         end
         default: begin
            store_strb  = 4'b1111;
            store_wdata = store_data_i;
         end
      endcase
      if (!mem_write_i) begin
         store_strb = 4'b0000;
      end
   end

   // Select the addressed lane from the returned word and extend it to
   // 32 bits. A store retires with zero load data.
   always_comb begin
      load_byte = dmem_rdata_i[7:0];
      case (lat_offset)
         2'b00: load_byte = dmem_rdata_i[7:0];
         2'b01: load_byte = dmem_rdata_i[15:8];
         2'b10: load_byte = dmem_rdata_i[23:16];
         2'b11: load_byte = dmem_rdata_i[31:24];
         default: load_byte = dmem_rdata_i[7:0];
      endcase
      load_half = lat_offset[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (lat_funct3)
         3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
         3'b001:  load_ext = {{16{load_half[15]}}, load_half};
         3'b100:  load_ext = {24'd0, load_byte};
         3'b101:  load_ext = {16'd0, load_half};
         default: load_ext = dmem_rdata_i;
      endcase
      retire_data = lat_is_store ? 32'd0 : load_ext;
   end

   // Stage state machine together with the memory request and MEM/WB
   // registers. valid_o is cleared every cycle and only pulses when an
   // instruction retires. Everything else holds its value between updates.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state            <= IDLE;
         dmem_req_o       <= 1'b0;
         dmem_we_o        <= 1'b0;
         dmem_addr_o      <= 32'd0;
         dmem_wdata_o     <= 32'd0;
         dmem_wstrb_o     <= 4'd0;
         valid_o          <= 1'b0;
         data_read_o      <= 32'd0;
         alu_result_o     <= 32'd0;
         pcsrc_o          <= 32'd0;
         offset_o         <= 32'd0;
         mem_to_reg_o     <= 2'd0;
         reg_write_o      <= 1'b0;
         rd_o             <= 5'd0;
         fault_o          <= 1'b0;
         lat_funct3       <= 3'd0;
         lat_offset       <= 2'd0;
         lat_is_store     <= 1'b0;
         lat_alu_result   <= 32'd0;
         lat_pcsrc        <= 32'd0;
         lat_offset_field <= 32'd0;
         lat_mem_to_reg   <= 2'd0;
         lat_reg_write    <= 1'b0;
         lat_rd           <= 5'd0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_i) begin
                  if (!is_mem || access_fault) begin
                     // Retire directly. A faulting access never reaches
                     // memory, and its register write is suppressed.
                     valid_o      <= 1'b1;
                     data_read_o  <= 32'd0;
                     alu_result_o <= alu_result_i;
                     pcsrc_o      <= pcsrc_i;
                     offset_o     <= offset_i;
                     mem_to_reg_o <= mem_to_reg_i;
                     reg_write_o  <= reg_write_i & ~access_fault;
                     rd_o         <= rd_i;
                     fault_o      <= access_fault;
                  end else begin
                     lat_funct3       <= funct3_i;
                     lat_offset       <= byte_off;
                     lat_is_store     <= mem_write_i;
                     lat_alu_result   <= alu_result_i;
                     lat_pcsrc        <= pcsrc_i;
                     lat_offset_field <= offset_i;
                     lat_mem_to_reg   <= mem_to_reg_i;
                     lat_reg_write    <= reg_write_i;
                     lat_rd           <= rd_i;
                     dmem_req_o       <= 1'b1;
                     dmem_we_o        <= mem_write_i;
                     dmem_addr_o      <= {alu_result_i[31:2], 2'b00};
                     dmem_wdata_o     <= store_wdata;
                     dmem_wstrb_o     <= store_strb;
                     state            <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (dmem_ack_i) begin
                  dmem_req_o   <= 1'b0;
                  dmem_we_o    <= 1'b0;
                  valid_o      <= 1'b1;
                  data_read_o  <= retire_data;
                  alu_result_o <= lat_alu_result;
                  pcsrc_o      <= lat_pcsrc;
                  offset_o     <= lat_offset_field;
                  mem_to_reg_o <= lat_mem_to_reg;
                  reg_write_o  <= lat_reg_write;
                  rd_o         <= lat_rd;
                  fault_o      <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Testbench for mem_access_stage. Each instruction's expected MEM/WB record
// is queued when the instruction is driven. A monitor pops and compares a
// record whenever the DUT pulses valid_o. The scenario tasks also check the
// memory request fields and the stall behaviour inline.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        valid_i;
   logic [31:0] alu_result_i;
   logic [31:0] store_data_i;
   logic [2:0]  funct3_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [1:0]  mem_to_reg_i;
   logic        reg_write_i;
   logic [4:0]  rd_i;
   logic [31:0] pcsrc_i;
   logic [31:0] offset_i;
   logic        stall_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_wstrb_o;
   logic [31:0] dmem_rdata_i;
   logic        dmem_ack_i;
   logic        valid_o;
   logic [31:0] data_read_o;
   logic [31:0] alu_result_o;
   logic [31:0] pcsrc_o;
   logic [31:0] offset_o;
   logic [1:0]  mem_to_reg_o;
   logic        reg_write_o;
   logic [4:0]  rd_o;
   logic        fault_o;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] alu;
      logic [31:0] pcsrc;
      logic [31:0] offset;
      logic [1:0]  m2r;
      logic        rw;
      logic [4:0]  rd;
      logic        fault;
   } retire_t;

   retire_t exp_q[$];
   int total = 0;
   int bad   = 0;
   int tag   = 0;

   mem_access_stage dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .valid_i      (valid_i),
      .alu_result_i (alu_result_i),
      .store_data_i (store_data_i),
      .funct3_i     (funct3_i),
      .mem_read_i   (mem_read_i),
      .mem_write_i  (mem_write_i),
      .mem_to_reg_i (mem_to_reg_i),
      .reg_write_i  (reg_write_i),
      .rd_i         (rd_i),
      .pcsrc_i      (pcsrc_i),
      .offset_i     (offset_i),
      .stall_o      (stall_o),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_wstrb_o (dmem_wstrb_o),
      .dmem_rdata_i (dmem_rdata_i),
      .dmem_ack_i   (dmem_ack_i),
      .valid_o      (valid_o),
      .data_read_o  (data_read_o),
      .alu_result_o (alu_result_o),
      .pcsrc_o      (pcsrc_o),
      .offset_o     (offset_o),
      .mem_to_reg_o (mem_to_reg_o),
      .reg_write_o  (reg_write_o),
      .rd_o         (rd_o),
      .fault_o      (fault_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference load extraction: shift the addressed lane down, then extend.
   function automatic logic [31:0] model_load(input logic [2:0] f3,
                                              input logic [1:0] a,
                                              input logic [31:0] w);
      logic [31:0] sh;
      sh = w >> (8 * a);
      case (f3)
         3'b000: return {{24{sh[7]}}, sh[7:0]};
         3'b100: return {24'd0, sh[7:0]};
         3'b001: begin
            sh = w >> (16 * a[1]);
            return {{16{sh[15]}}, sh[15:0]};
         end
         3'b101: begin
            sh = w >> (16 * a[1]);
            return {16'd0, sh[15:0]};
         end
         default: return w;
      endcase
   endfunction

   // Monitor: every valid_o pulse must match the oldest queued record.
   always @(negedge clk_i) begin
      retire_t e;
      if (reset_i === 1'b1 && valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_retire: got valid_o=1 rd=%0d alu=%h, required no retirement",
                     rd_o, alu_result_o);
         end else begin
            e = exp_q.pop_front();
            total++;
            if (data_read_o !== e.data) begin
               bad++;
               $display("[TB] FAIL retire_data: got %h, required %h", data_read_o, e.data);
            end
            total++;
            if (fault_o !== e.fault) begin
               bad++;
               $display("[TB] FAIL retire_fault: got %b, required %b", fault_o, e.fault);
            end
            total++;
            if (reg_write_o !== e.rw) begin
               bad++;
               $display("[TB] FAIL retire_reg_write: got %b, required %b", reg_write_o, e.rw);
            end
            total++;
            if ({alu_result_o, pcsrc_o, offset_o, mem_to_reg_o, rd_o} !==
                {e.alu, e.pcsrc, e.offset, e.m2r, e.rd}) begin
               bad++;
               $display("[TB] FAIL retire_passthru: got alu=%h pc=%h off=%h m2r=%0d rd=%0d, required alu=%h pc=%h off=%h m2r=%0d rd=%0d",
                        alu_result_o, pcsrc_o, offset_o, mem_to_reg_o, rd_o,
                        e.alu, e.pcsrc, e.offset, e.m2r, e.rd);
            end
         end
      end
   end

   // Drive one instruction onto the EX/MEM inputs and queue its expected
   // retirement record.
   task automatic drive_op(input logic rd_en, input logic wr_en,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [2:0] f3, input logic [4:0] rd,
                           input logic [1:0] m2r, input logic exp_fault,
                           input logic [31:0] exp_data);
      retire_t e;
      tag++;
      valid_i      = 1'b1;
      mem_read_i   = rd_en;
      mem_write_i  = wr_en;
      alu_result_i = addr;
      store_data_i = sdata;
      funct3_i     = f3;
      rd_i         = rd;
      mem_to_reg_i = m2r;
      reg_write_i  = ~wr_en;
      pcsrc_i      = 32'h0040_0000 + tag * 4;
      offset_i     = 32'h0000_0100 + tag;
      e.data   = exp_data;
      e.alu    = addr;
      e.pcsrc  = pcsrc_i;
      e.offset = offset_i;
      e.m2r    = m2r;
      e.rw     = reg_write_i & ~exp_fault;
      e.rd     = rd;
      e.fault  = exp_fault;
      exp_q.push_back(e);
   endtask

   task automatic bubble();
      valid_i     = 1'b0;
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
   endtask

   // Act as the memory: check the request the cycle after acceptance, check
   // it stays stable for the wait cycles, then raise ack with read data.
   task automatic respond(input int waits, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic e_we,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata,
                          input logic chk_wdata, input string name);
      @(negedge clk_i);
      total++;
      if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, stall_o} !==
          {1'b1, e_we, e_addr, e_strb, 1'b1}) begin
         bad++;
         $display("[TB] FAIL %s_request: got req=%b we=%b addr=%h strb=%b stall=%b, required req=1 we=%b addr=%h strb=%b stall=1",
                  name, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, stall_o,
                  e_we, e_addr, e_strb);
      end
      if (chk_wdata) begin
         total++;
         if (dmem_wdata_o !== e_wdata) begin
            bad++;
            $display("[TB] FAIL %s_wdata: got %h, required %h", name, dmem_wdata_o, e_wdata);
         end
      end
      for (int i = 0; i < waits; i++) begin
         @(negedge clk_i);
         total++;
         if ({dmem_req_o, dmem_addr_o, dmem_wstrb_o, stall_o, valid_o} !==
             {1'b1, e_addr, e_strb, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL %s_hold: got req=%b addr=%h strb=%b stall=%b valid=%b, required req=1 addr=%h strb=%b stall=1 valid=0",
                     name, dmem_req_o, dmem_addr_o, dmem_wstrb_o, stall_o, valid_o,
                     e_addr, e_strb);
         end
      end
      dmem_rdata_i = rdata;
      dmem_ack_i   = 1'b1;
   endtask

   task automatic finish_ack(input string name);
      @(negedge clk_i);
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h5A5A_5A5A;
      total++;
      if ({stall_o, dmem_req_o, valid_o} !== 3'b001) begin
         bad++;
         $display("[TB] FAIL %s_retire: got stall=%b req=%b valid=%b, required stall=0 req=0 valid=1",
                  name, stall_o, dmem_req_o, valid_o);
      end
   endtask

   task automatic check_all_zero(input string name);
      total++;
      if (|{stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
            valid_o, data_read_o, alu_result_o, pcsrc_o, offset_o, mem_to_reg_o,
            reg_write_o, rd_o, fault_o} !== 1'b0) begin
         bad++;
         $display("[TB] FAIL %s: got stall=%b req=%b addr=%h valid=%b data=%h alu=%h rd=%0d, required all outputs 0",
                  name, stall_o, dmem_req_o, dmem_addr_o, valid_o, data_read_o, alu_result_o, rd_o);
      end
   endtask

   task automatic test_reset();
      reset_i      = 1'b0;
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h0;
      alu_result_i = 32'h0;
      store_data_i = 32'h0;
      funct3_i     = 3'b0;
      mem_to_reg_i = 2'b0;
      reg_write_i  = 1'b0;
      rd_i         = 5'd0;
      pcsrc_i      = 32'h0;
      offset_i     = 32'h0;
      bubble();
      repeat (2) @(negedge clk_i);
      check_all_zero("reset_state");
      reset_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_reset_mid_wait();
      drive_op(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 5'd3, 2'b01, 1'b0, 32'h0);
      @(negedge clk_i);
      bubble();
      total++;
      if (dmem_req_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midwait_req: got %b, required 1", dmem_req_o);
      end
      #2 reset_i = 1'b0;
      #1 check_all_zero("midwait_reset");
      exp_q.delete();
      @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = 32'hFFFF_FFFF;
      @(negedge clk_i);
      dmem_ack_i = 1'b0;
      total++;
      if ({valid_o, dmem_req_o, stall_o} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL late_ack: got valid=%b req=%b stall=%b, required 0 0 0",
                  valid_o, dmem_req_o, stall_o);
      end
   endtask

   task automatic test_load_byte();
      drive_op(1'b1, 1'b0, 32'h203, 32'h0, 3'b000, 5'd7, 2'b01, 1'b0,
               model_load(3'b000, 2'd3, 32'h80FF_0000));
      respond(0, 32'h80FF_0000, 32'h200, 1'b0, 4'b0000, 32'h0, 1'b0, "lb");
      bubble();
      finish_ack("lb");
   endtask

   task automatic test_load_half_waits();
      drive_op(1'b1, 1'b0, 32'h202, 32'h0, 3'b101, 5'd9, 2'b01, 1'b0,
               model_load(3'b101, 2'd2, 32'h8001_1234));
      respond(3, 32'h8001_1234, 32'h200, 1'b0, 4'b0000, 32'h0, 1'b0, "lhu");
      bubble();
      finish_ack("lhu");
   endtask

   task automatic test_loads_table();
      logic [31:0] addrs [5] = '{32'h102, 32'h0, 32'h201, 32'h200, 32'h100};
      logic [2:0]  f3s   [5] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b001};
      logic [31:0] words [5] = '{32'h8001_7FFF, 32'hCAFE_BABE, 32'h0000_F200,
                                 32'h0000_007F, 32'h0000_FFFE};
      for (int i = 0; i < 5; i++) begin
         drive_op(1'b1, 1'b0, addrs[i], 32'h0, f3s[i], 5'(10 + i), 2'b01, 1'b0,
                  model_load(f3s[i], addrs[i][1:0], words[i]));
         respond(i % 3, words[i], {addrs[i][31:2], 2'b00}, 1'b0, 4'b0000, 32'h0,
                 1'b0, "load_tbl");
         bubble();
         finish_ack("load_tbl");
      end
   endtask

   task automatic test_stores();
      logic [31:0] addrs [4] = '{32'h101, 32'h102, 32'h40, 32'h3};
      logic [2:0]  f3s   [4] = '{3'b000, 3'b001, 3'b010, 3'b000};
      logic [31:0] sdata [4] = '{32'h1234_56AB, 32'hAAAA_BEEF, 32'h1234_5678, 32'h0000_00C3};
      logic [3:0]  strb  [4] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000};
      logic [31:0] wdata [4] = '{32'hABAB_ABAB, 32'hBEEF_BEEF, 32'h1234_5678, 32'hC3C3_C3C3};
      for (int i = 0; i < 4; i++) begin
         drive_op(1'b0, 1'b1, addrs[i], sdata[i], f3s[i], 5'd0, 2'b00, 1'b0, 32'h0);
         respond(i % 2, 32'hFFFF_FFFF, {addrs[i][31:2], 2'b00}, 1'b1, strb[i],
                 wdata[i], 1'b1, "store");
         bubble();
         finish_ack("store");
      end
   endtask

   task automatic test_faults();
      logic [31:0] addrs [4] = '{32'h102, 32'h101, 32'h0, 32'h203};
      logic [2:0]  f3s   [4] = '{3'b010, 3'b001, 3'b011, 3'b101};
      logic        wr    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         drive_op(~wr[i], wr[i], addrs[i], 32'h5555_5555, f3s[i], 5'(20 + i),
                  2'b01, 1'b1, 32'h0);
         @(negedge clk_i);
         total++;
         if ({dmem_req_o, stall_o, valid_o} !== 3'b001) begin
            bad++;
            $display("[TB] FAIL fault_no_req: got req=%b stall=%b valid=%b, required req=0 stall=0 valid=1",
                     dmem_req_o, stall_o, valid_o);
         end
      end
      bubble();
      @(negedge clk_i);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         drive_op(1'b0, 1'b0, 32'h1111_0000 + i, 32'h0, 3'b000, 5'(1 + i), 2'b00,
                  1'b0, 32'h0);
         @(negedge clk_i);
         total++;
         if ({stall_o, valid_o} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL b2b_flow: got stall=%b valid=%b, required stall=0 valid=1",
                     stall_o, valid_o);
         end
      end
      bubble();
      @(negedge clk_i);
   endtask

   task automatic test_mixed();
      drive_op(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 3'b000, 5'd5, 2'b00, 1'b0, 32'h0);
      @(negedge clk_i);
      total++;
      if (valid_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mixed_add1: got valid=%b, required 1", valid_o);
      end
      drive_op(1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, 3'b010, 5'd0, 2'b00, 1'b0, 32'h0);
      respond(2, 32'h0, 32'h40, 1'b1, 4'b1111, 32'h0BAD_F00D, 1'b1, "mixed_sw");
      drive_op(1'b0, 1'b0, 32'h0000_1234, 32'h0, 3'b000, 5'd6, 2'b00, 1'b0, 32'h0);
      finish_ack("mixed_sw");
      @(negedge clk_i);
      bubble();
      total++;
      if ({valid_o, rd_o} !== {1'b1, 5'd6}) begin
         bad++;
         $display("[TB] FAIL mixed_add2: got valid=%b rd=%0d, required valid=1 rd=6",
                  valid_o, rd_o);
      end
      @(negedge clk_i);
   endtask

   task automatic test_ack_idle();
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = 32'h1234_5678;
      @(negedge clk_i);
      dmem_ack_i = 1'b0;
      total++;
      if ({valid_o, dmem_req_o, stall_o} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL idle_ack: got valid=%b req=%b stall=%b, required 0 0 0",
                  valid_o, dmem_req_o, stall_o);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion, required completion before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_reset_mid_wait();
      test_load_byte();
      test_load_half_waits();
      test_loads_table();
      test_stores();
      test_faults();
      test_back_to_back();
      test_mixed();
      test_ack_idle();
      repeat (3) @(negedge clk_i);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: got %0d pending retirements, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
